lcd_rd_ctrl: RTL

LCD_RD_CTRL -- requirements
Module: lcd_rd_ctrl

---
 rtl/lcd_rd_ctrl_if.sv | 30 +++
 rtl/lcd_rd_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/lcd_rd_ctrl_if.sv
// rtl/lcd_rd_ctrl_if.sv - request/response and LCD bus signals of the LCD read controller
interface lcd_rd_ctrl_if;
    logic       rd_req;
    logic [1:0] rd_mode;
    logic [7:0] lcd_db_in;
    logic       lcd_db_oe;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       rd_busy;
    logic       rd_done;
    logic [7:0] rd_data;
    logic       bf;
    logic [6:0] ac;
    logic [3:0] hex_nib;
    logic       hex_valid;
    logic       timeout;

    modport master (
        output rd_req, rd_mode, lcd_db_in,
        input  lcd_db_oe, lcd_rs, lcd_rw, lcd_en, rd_busy, rd_done,
        input  rd_data, bf, ac, hex_nib, hex_valid, timeout
    );

    modport slave (
        input  rd_req, rd_mode, lcd_db_in,
        output lcd_db_oe, lcd_rs, lcd_rw, lcd_en, rd_busy, rd_done,
        output rd_data, bf, ac, hex_nib, hex_valid, timeout
    );
endinterface

// File: rtl/lcd_rd_ctrl.sv
// rtl/lcd_rd_ctrl.sv - HD44780-style LCD read sequencer with busy-flag polling and hex decode
module lcd_rd_ctrl #(
    parameter int POLL_MAX = 650
) (
    input  logic          oneUSClk,
    input  logic          reset,
    lcd_rd_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SETUP, EN_HI, EN_LO, DONE} state_t;

    localparam logic [9:0] POLL_LAST = 10'(POLL_MAX - 1);

    state_t     state;
    logic [1:0] mode;
    logic [9:0] poll_cnt;
    logic       hi_second;
    logic       poll_more;

    // Only BF/AC polling with the busy flag still set keeps the loop going.
    always_comb begin
        poll_more = (mode == 2'b01) && bus.bf;
    end

    always_ff @(posedge oneUSClk) begin
        if (reset) begin
            state         <= IDLE;
            mode          <= 2'b00;
            poll_cnt      <= 10'd0;
            hi_second     <= 1'b0;
            bus.lcd_en    <= 1'b0;
            bus.lcd_rw    <= 1'b0;
            bus.lcd_rs    <= 1'b0;
            bus.lcd_db_oe <= 1'b1;
            bus.rd_busy   <= 1'b0;
            bus.rd_done   <= 1'b0;
            bus.rd_data   <= 8'h00;
            bus.bf        <= 1'b0;
            bus.ac        <= 7'h00;
            bus.timeout   <= 1'b0;
        end else begin
            bus.rd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rd_req) begin
                        state         <= SETUP;
                        mode          <= bus.rd_mode;
                        poll_cnt      <= 10'd0;
                        bus.timeout   <= 1'b0;
                        bus.rd_busy   <= 1'b1;
                        bus.lcd_rw    <= 1'b1;
                        bus.lcd_db_oe <= 1'b0;
                        bus.lcd_rs    <= (bus.rd_mode == 2'b10);
                        bus.lcd_en    <= 1'b0;
                    end
                end
                SETUP: begin
                    state      <= EN_HI;
                    hi_second  <= 1'b0;
                    bus.lcd_en <= 1'b1;
                end
                EN_HI: begin
                    if (!hi_second) begin
                        hi_second <= 1'b1;
                    end else begin
                        // Panel data is valid by the end of the second enable-high cycle.
                        state       <= EN_LO;
                        bus.lcd_en  <= 1'b0;
                        bus.rd_data <= bus.lcd_db_in;
                        bus.bf      <= bus.lcd_db_in[7];
                        bus.ac      <= bus.lcd_db_in[6:0];
                    end
                end
                EN_LO: begin
                    if (poll_more && (poll_cnt < POLL_LAST)) begin
                        poll_cnt <= poll_cnt + 10'd1;
                        state    <= SETUP;
                    end else begin
                        state         <= DONE;
                        bus.timeout   <= poll_more;
                        bus.rd_done   <= 1'b1;
                        bus.lcd_rw    <= 1'b0;
                        bus.lcd_rs    <= 1'b0;
                        bus.lcd_db_oe <= 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    bus.rd_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ASCII hex character to nibble; letters in either case map to A-F.
    always_comb begin
        bus.hex_nib   = 4'h0;
        bus.hex_valid = 1'b0;
        if (bus.rd_data >= 8'h30 && bus.rd_data <= 8'h39) begin
            bus.hex_nib   = bus.rd_data[3:0];
            bus.hex_valid = 1'b1;
        end else if ((bus.rd_data >= 8'h41 && bus.rd_data <= 8'h46) ||
                     (bus.rd_data >= 8'h61 && bus.rd_data <= 8'h66)) begin
            bus.hex_nib   = bus.rd_data[3:0] + 4'd9;
            bus.hex_valid = 1'b1;
        end
    end
endmodule
